// File: rtl/btn_matrix_scanner_if.sv
// ---------------------------------------------------------------------------
// btn_matrix_scanner_if
// Purpose : carries the key-event bus from the button matrix scanner to the
//           game logic that consumes key presses.
// Signals :
//   key_valid  one-cycle pulse, a key was accepted (or auto-repeated)
//   key_code   row*4+col of the accepted key, held until the next key_valid
//   key_held   high while the accepted key is still pressed
// Modports:
//   master  the scanner, which drives all three signals
//   slave   the consumer, which only reads them
// ---------------------------------------------------------------------------
interface btn_matrix_scanner_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_held;

  modport master (output key_valid, output key_code, output key_held);
  modport slave  (input  key_valid, input  key_code, input  key_held);
endinterface

// File: rtl/btn_matrix_scanner.sv
// ---------------------------------------------------------------------------
// btn_matrix_scanner
// Purpose : scans the 5x4 SWORD button matrix by pulling one BTN_X row low at
//           a time and sampling the BTN_Y columns. The first key found is
//           debounced and reported as a one-cycle event with a row/column
//           code. This block is the only driver of the matrix rows.
// Ports   :
//   clk          system clock
//   reset        synchronous, active-high reset
//   scan_en      1 = scan, 0 = pause with every row released
//   col_in_n     BTN_Y column sense, active-low, asynchronous to clk
//   row_drive_n  BTN_X row drive, active-low, at most one bit low
//   key_bus      key event bus (key_valid / key_code / key_held), master side
// Configuration:
//   BTN_AUTO_REPEAT_EN  when defined, a held key re-issues key_valid after
//                       REPEAT_DELAY clocks and then every REPEAT_RATE clocks.
//                       When undefined there is exactly one event per press.
// ---------------------------------------------------------------------------
module btn_matrix_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scan_en,
  input  logic [3:0]                  col_in_n,
  output logic [4:0]                  row_drive_n,
  btn_matrix_scanner_if.master        key_bus
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_s_q, col_s_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic             active_q, active_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lat_col_q, lat_col_d;
  logic             key_valid_q, key_valid_d;
  logic [4:0]       key_code_q, key_code_d;
  logic             key_held_q, key_held_d;

  logic [2:0]       next_row;
  logic [1:0]       first_low;
  logic             lat_col_low;
  logic [DEB_W-1:0] cnt_inc;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_seen_q, rep_seen_d;
  logic [REP_W-1:0] rep_limit;
`else
  // Repeat timing has no meaning without the repeat feature; fold the
  // parameters into a sink so they remain part of the interface.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // The active row is decoded straight from the row index; while paused
  // every row is released so no key can load the column lines.
  assign row_drive_n = active_q ? ~(5'b00001 << row_q) : 5'b11111;

  assign key_bus.key_valid = key_valid_q;
  assign key_bus.key_code  = key_code_q;
  assign key_bus.key_held  = key_held_q;

  // Helpers: wrap-around row step, lowest-index low column (col 0 has
  // priority), and the debounced view of the latched column.
  always_comb begin
    next_row    = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
    lat_col_low = ~col_s_q[lat_col_q];
    cnt_inc     = cnt_q + DEB_W'(1);
    first_low   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) first_low = 2'(i);
    end
  end

  // Next-state logic for synchronizer, scan sequencing, debounce and the
  // key event outputs. scan_en low overrides every state and quietly parks
  // the scanner at row 0 with rows released, keeping the last key_code.
  always_comb begin
    col_meta_d  = col_in_n;
    col_s_d     = col_meta_q;
    state_d     = state_q;
    row_d       = row_q;
    active_d    = active_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    lat_col_d   = lat_col_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
`ifdef BTN_AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_seen_d  = rep_seen_q;
    rep_limit   = rep_seen_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    if (!scan_en) begin
      active_d   = 1'b0;
      row_d      = 3'd0;
      state_d    = ST_SCAN;
      dwell_d    = '0;
      cnt_d      = '0;
      key_held_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_d      = '0;
      rep_seen_d = 1'b0;
`endif
    end else begin
      active_d = 1'b1;
      case (state_q)
        ST_SCAN: begin
          // The dwell stays at 0 on the cycle the rows come back on so the
          // first row gets a full dwell through the synchronizer.
          if (!active_q) begin
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (&col_s_q) begin
              row_d = next_row;
            end else begin
              lat_col_d = first_low;
              cnt_d     = '0;
              state_d   = ST_DEBOUNCE;
            end
          end else begin
            dwell_d = dwell_q + DIV_W'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (lat_col_low) begin
            if (cnt_inc == DEB_LAST) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_q, lat_col_q};
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
`ifdef BTN_AUTO_REPEAT_EN
              rep_d       = '0;
              rep_seen_d  = 1'b0;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            dwell_d = '0;
            row_d   = next_row;
            state_d = ST_SCAN;
          end
        end

        ST_HELD: begin
          // Here cnt counts consecutive released samples; any low sample
          // is treated as bounce and restarts the release window.
          if (lat_col_low) begin
            cnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
            if (rep_q == rep_limit) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
              rep_seen_d  = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
`endif
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            rep_d = '0;
`endif
            if (cnt_inc == DEB_LAST) begin
              key_held_d = 1'b0;
              cnt_d      = '0;
              dwell_d    = '0;
              row_d      = next_row;
              state_d    = ST_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; the synchronizer idles high to
  // match an unpressed matrix.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q  <= 4'hF;
      col_s_q     <= 4'hF;
      state_q     <= ST_SCAN;
      row_q       <= 3'd0;
      active_q    <= 1'b1;
      dwell_q     <= '0;
      cnt_q       <= '0;
      lat_col_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 5'd0;
      key_held_q  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_q       <= '0;
      rep_seen_q  <= 1'b0;
`endif
    end else begin
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
      state_q     <= state_d;
      row_q       <= row_d;
      active_q    <= active_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      lat_col_q   <= lat_col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
`ifdef BTN_AUTO_REPEAT_EN
      rep_q       <= rep_d;
      rep_seen_q  <= rep_seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_btn_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_btn_matrix_scanner
// Purpose : directed bench for btn_matrix_scanner with small timing
//           parameters. A behavioural matrix model turns the set of pressed
//           keys plus the current row drive into column levels. Expected key
//           codes are queued when a press is driven and consumed by a monitor
//           whenever key_valid pulses.
// ---------------------------------------------------------------------------
module tb_btn_matrix_scanner;

  localparam int unsigned SCAN_DIV        = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;
  localparam int unsigned REPEAT_DELAY    = 40;
  localparam int unsigned REPEAT_RATE     = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [3:0]  col_in_n;
  logic [4:0]  row_drive_n;
  logic [19:0] pressed;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int cyc    = 0;
  int exp_q[$];
  int vtimes[$];

  btn_matrix_scanner_if key_bus ();

  btn_matrix_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .col_in_n    (col_in_n),
    .row_drive_n (row_drive_n),
    .key_bus     (key_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix model: a pressed key pulls its column low only while its row
  // is driven low.
  always_comb begin
    col_in_n = 4'hF;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_drive_n[r] == 1'b0 && pressed[r*4+c]) col_in_n[c] = 1'b0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every key_valid must match a queued expectation.
  always @(negedge clk) begin
    if (key_bus.key_valid === 1'b1) begin
      vcount++;
      vtimes.push_back(cyc);
      check_output("valid_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_output("key_code", 32'(key_bus.key_code), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_row(input logic [4:0] pat, input int budget, input string tag);
    int n = 0;
    while (row_drive_n !== pat && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(row_drive_n), 32'(pat));
  endtask

  task automatic apply_stimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    int t0;
    int n_exp;
    int offs[4];
    logic [4:0] exp_row;

    offs = '{40, 56, 72, 88};
    reset   = 1'b1;
    scan_en = 1'b1;
    pressed = '0;

    // Reset state, then row stepping every SCAN_DIV clocks with wrap.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_row", 32'(row_drive_n), 32'h1E);
    check_output("reset_valid", 32'(key_bus.key_valid), 32'd0);
    check_output("reset_held", 32'(key_bus.key_held), 32'd0);
    check_output("reset_code", 32'(key_bus.key_code), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_row = ~(5'b00001 << ((k / 4) % 5));
      check_output($sformatf("row_step_%0d", k), 32'(row_drive_n), 32'(exp_row));
    end

    // Single press on row3/col0 held 100 clocks.
    base = vcount;
    exp_q.push_back(12);
    pressed[12] = 1'b1;
    apply_stimulus(100);
    check_output("press12_count", 32'(vcount - base), 32'd1);
    check_output("press12_held", 32'(key_bus.key_held), 32'd1);
    check_output("press12_code", 32'(key_bus.key_code), 32'd12);
    pressed[12] = 1'b0;
    apply_stimulus(3);
    check_output("release_held_early", 32'(key_bus.key_held), 32'd1);
    apply_stimulus(9);
    check_output("release_held_late", 32'(key_bus.key_held), 32'd0);

    // Short 5-clock press during debounce produces nothing.
    base = vcount;
    wait_row(5'b10111, 40, "short_wait_row3");
    pressed[12] = 1'b1;
    apply_stimulus(5);
    pressed[12] = 1'b0;
    apply_stimulus(4);
    check_output("short_resume_row4", 32'(row_drive_n), 32'h0F);
    apply_stimulus(10);
    check_output("short_no_valid", 32'(vcount - base), 32'd0);

    // Two keys on row 1: lowest column wins.
    base = vcount;
    exp_q.push_back(6);
    pressed[6] = 1'b1;
    pressed[7] = 1'b1;
    apply_stimulus(60);
    check_output("dual_count", 32'(vcount - base), 32'd1);
    check_output("dual_code", 32'(key_bus.key_code), 32'd6);
    pressed[6] = 1'b0;
    pressed[7] = 1'b0;
    apply_stimulus(15);
    check_output("dual_released", 32'(key_bus.key_held), 32'd0);

    // Reset asserted during debounce.
    base = vcount;
    wait_row(5'b10111, 40, "rst_wait_row3");
    pressed[12] = 1'b1;
    apply_stimulus(6);
    reset = 1'b1;
    pressed[12] = 1'b0;
    apply_stimulus(1);
    check_output("rst_row", 32'(row_drive_n), 32'h1E);
    check_output("rst_valid", 32'(key_bus.key_valid), 32'd0);
    check_output("rst_code", 32'(key_bus.key_code), 32'd0);
    reset = 1'b0;
    apply_stimulus(20);
    check_output("rst_no_valid", 32'(vcount - base), 32'd0);

    // scan_en dropped while a key is held.
    base = vcount;
    exp_q.push_back(12);
    pressed[12] = 1'b1;
    n = 0;
    while (key_bus.key_held !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("pause_reach_held", 32'(key_bus.key_held), 32'd1);
    apply_stimulus(5);
    scan_en = 1'b0;
    apply_stimulus(1);
    check_output("pause_row", 32'(row_drive_n), 32'h1F);
    check_output("pause_held", 32'(key_bus.key_held), 32'd0);
    check_output("pause_code_kept", 32'(key_bus.key_code), 32'd12);
    apply_stimulus(3);
    check_output("pause_row_stays", 32'(row_drive_n), 32'h1F);
    pressed[12] = 1'b0;
    scan_en = 1'b1;
    apply_stimulus(1);
    check_output("resume_row0", 32'(row_drive_n), 32'h1E);
    apply_stimulus(4);
    check_output("resume_row1", 32'(row_drive_n), 32'h1D);
    check_output("pause_count", 32'(vcount - base), 32'd1);

    // Long hold on row4/col1: one event, or the repeat train when enabled.
`ifdef BTN_AUTO_REPEAT_EN
    n_exp = 5;
`else
    n_exp = 1;
`endif
    base = vcount;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(17);
    pressed[17] = 1'b1;
    n = 0;
    while (vcount == base && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_output("long_accept_seen", 32'(vcount > base), 32'd1);
    t0 = (vtimes.size() > base) ? vtimes[base] : 0;
    apply_stimulus(95);
    pressed[17] = 1'b0;
    apply_stimulus(15);
    check_output("long_count", 32'(vcount - base), 32'(n_exp));
    check_output("long_released", 32'(key_bus.key_held), 32'd0);
`ifdef BTN_AUTO_REPEAT_EN
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("repeat_offset_%0d", i),
                   32'((vtimes.size() > base + i + 1) ? vtimes[base + i + 1] - t0 : -1),
                   32'(offs[i]));
    end
`else
    check_output("single_event_time", 32'(t0 > 0), 32'd1);
`endif

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
